updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised successor to the team's 8-bit up/down loadable counter. Adds:
- configurable width and step size
- a run-time programmable terminal value (`limit`)
- selectable wrap or saturate behaviour
- terminal flags and a registered overflow pulse

It sits in timer and sequencing datapaths wherever a bounded, bidirectional count is needed.

## Interface
- `WIDTH`, 8, counter width in bits (≥2)
- `STEP_W`, 4, width of the step input (1..WIDTH)
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous clear to 0
- `enable`  in  1  count enable
- `up_down`  in  1  1 = count up, 0 = count down
- `load`  in  1  synchronous load of `data_in`
- `data_in`  in  WIDTH  load value
- `step`  in  STEP_W  increment/decrement magnitude
- `limit`  in  WIDTH  terminal value; legal count range is 0..`limit`
- `sat_mode`  in  1  1 = saturate at bounds, 0 = wrap modulo `limit`+1
- `count`  out  WIDTH  current count (registered)
- `at_max`  out  1  `count` == `limit` (combinational from `count`)
- `at_min`  out  1  `count` == 0 (combinational from `count`)
- `ovf`  out  1  registered one-cycle pulse: a bound was crossed on the previous edge

## Operation
- Priority per rising edge: `reset` low > `clear` > `load` > `enable` > hold.
- **Reset:** `reset` low forces `count` = 0 and `ovf` = 0 immediately. This applies mid-operation with no clock. Flags follow `count`.
- **Clear:** `count` ← 0, `ovf` ← 0.
- **Load:** `count` ← min(`data_in`, `limit`), `ovf` ← 0. Loading above `limit` clamps and does not pulse `ovf`.
- **Enable with `step` = 0:** `count` holds, `ovf` ← 0.
- **Out-of-range recovery:** if `count` > `limit` on an enabled cycle (e.g. `limit` lowered at run time), `count` ← `limit` and `ovf` ← 1, regardless of direction or mode.
- **Up count:** compute s = `count` + `step` in WIDTH+1 bits.
  - If s ≤ `limit`: `count` ← s.
  - Otherwise, wrap mode: `count` ← s − (`limit`+1), saturate mode: `count` ← `limit`. Both set `ovf` ← 1.
- **Down count:**
  - If `step` ≤ `count`: `count` ← `count` − `step`.
  - Otherwise, wrap mode: `count` ← `count` + (`limit`+1) − `step`, saturate mode: `count` ← 0. Both set `ovf` ← 1.
- **Effective step:** min(`step`, `limit`+1). This keeps wrap results in range. A step of exactly `limit`+1 in wrap mode returns the same count with `ovf` = 1.
- Saturate mode already at a bound and stepping further: `count` unchanged, `ovf` ← 1 on every such enabled cycle.
- `ovf` is 0 on any cycle that does not satisfy one of the overflow conditions above.
- All arithmetic is unsigned. Internal sums are WIDTH+1 bits, so `limit` = 2^WIDTH−1 works without loss.

## Timing
- `count` and `ovf` update on the rising edge following the qualifying inputs. Latency is one cycle.
- `ovf` is high for exactly one cycle per overflow event. Back-to-back events give a continuous high.
- `at_max`/`at_min` are valid in the same cycle as `count`. They reflect the current `limit` combinationally.
- `limit`, `step`, `sat_mode` and `up_down` are sampled on the same edge as `enable`. No pipeline exists, so a change takes effect on the next edge.
- Reset values: `count` = 0, `ovf` = 0, `at_min` = 1, `at_max` = (`limit` == 0).

## Structure
- Shared package `counter_pkg`:
  - direction constants `CNT_DOWN` = 0, `CNT_UP` = 1
  - mode constants `MODE_WRAP` = 0, `MODE_SAT` = 1
- Sub-module `counter_next_calc`:
  - purely combinational
  - inputs: `count`, `step`, `limit`, `up_down`, `sat_mode`
  - outputs: next value and overflow bit
- The top level holds the priority mux and the two registers (`count`, `ovf`).

## Test plan
- WIDTH=8, `limit`=9, wrap, up, `step`=3 from 0 → 3, 6, 9, 2 (`ovf`=1 on the edge to 2), then 5.
- `limit`=9, saturate, down, `step`=4 from 7 → 3, 0 (`ovf`=1), 0 (`ovf`=1). `at_min`=1 from the first 0.
- Load `data_in`=200 with `limit`=100 → `count`=100, `ovf`=0, `at_max`=1. Next: `limit` lowered to 50 with `enable` → `count`=50, `ovf`=1.
- Simultaneous `clear`, `load` and `enable` → `count`=0. `load` and `enable` together with `data_in`=5 → `count`=5 (no step applied).
- `limit`=255, wrap, up, `step`=1 from 255 → 0 with `ovf`=1. `step`=0 with `enable` → count holds, `ovf`=0.
- Assert `reset` low between clock edges while counting → `count`=0 and `ovf`=0 immediately. After release, counting resumes from 0 on the first enabled edge.

Source files
------------

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//
// Shared encodings for the up/down modulo counter family. The counter
// datapath and anything that drives its control inputs import these so the
// meaning of the up_down and sat_mode bits is spelled out once.
//
// Contents:
//   CNT_DOWN / CNT_UP   values of the up_down input
//   MODE_WRAP / MODE_SAT values of the sat_mode input
// ----------------------------------------------------------------------------
package counter_pkg;

    // Direction select.
    localparam logic CNT_DOWN  = 1'b0;
    localparam logic CNT_UP    = 1'b1;

    // Bound behaviour select.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_next_calc.sv
// ----------------------------------------------------------------------------
// counter_next_calc
//
// Purely combinational next-state calculation for an enabled counting cycle.
// Given the current count, the step and the terminal value it produces the
// count that the next edge must load and whether that edge is an overflow
// event. The priority between clear/load/enable lives in the top level; this
// block only answers "what happens if we count now".
//
// Ports:
//   count      in  WIDTH   current registered count
//   step       in  STEP_W  requested step magnitude
//   limit      in  WIDTH   terminal value, legal range is 0..limit
//   up_down    in  1       CNT_UP / CNT_DOWN
//   sat_mode   in  1       MODE_SAT / MODE_WRAP
//   next_count out WIDTH   count after this enabled cycle
//   next_ovf   out 1       this enabled cycle crosses (or recovers to) a bound
// ----------------------------------------------------------------------------
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              up_down,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              next_ovf
);

    // One extra bit everywhere so limit = 2^WIDTH-1 (range of 2^WIDTH values)
    // and count + step never lose a carry.
    localparam int EW = WIDTH + 1;

    logic [EW-1:0] count_x;
    logic [EW-1:0] limit_x;
    logic [EW-1:0] range_x;   // number of legal values, limit + 1
    logic [EW-1:0] step_x;
    logic [EW-1:0] eff_step;
    logic [EW-1:0] sum_x;

    assign count_x = {1'b0, count};
    assign limit_x = {1'b0, limit};
    assign range_x = limit_x + EW'(1);
    assign step_x  = EW'(step);

    // Clamp the step to one full lap. With count <= limit this guarantees a
    // single subtraction/addition of range_x brings any wrap back in range,
    // and a step of exactly one lap returns to the same count.
    assign eff_step = (step_x > range_x) ? range_x : step_x;

    assign sum_x = count_x + eff_step;

    // NOTE: every output gets a default first so no path through the
    // branches below leaves a value unassigned and infers a latch.
    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;

        if (count_x > limit_x) begin
            // Limit was lowered under a running count. Pull back to the
            // terminal value and flag it, whatever the direction, mode or
            // step; this keeps the wrap arithmetic below within its range.
            next_count = limit;
            next_ovf   = 1'b1;
        end else begin
            case (up_down)
                CNT_UP: begin
                    if (sum_x > limit_x) begin
                        next_ovf = 1'b1;
                        case (sat_mode)
                            MODE_SAT:  next_count = limit;
                            MODE_WRAP: next_count = WIDTH'(sum_x - range_x);
                        endcase
                    end else begin
                        next_count = WIDTH'(sum_x);
                    end
                end
                CNT_DOWN: begin
                    if (eff_step > count_x) begin
                        next_ovf = 1'b1;
                        case (sat_mode)
                            MODE_SAT:  next_count = '0;
                            // count + range - step: no borrow out because
                            // step <= range, result <= limit because
                            // step > count.
                            MODE_WRAP: next_count = WIDTH'(count_x + range_x - eff_step);
                        endcase
                    end else begin
                        next_count = WIDTH'(count_x - eff_step);
                    end
                end
            endcase
        end
    end

endmodule : counter_next_calc

// File: rtl/updown_mod_counter.sv
// ----------------------------------------------------------------------------
// updown_mod_counter
//
// Bounded bidirectional counter with a run-time terminal value, selectable
// wrap or saturate behaviour, terminal flags and a registered overflow pulse.
// The top level holds the control priority (clear > load > enable > hold)
// and the two state registers; the counting arithmetic is in
// counter_next_calc.
//
// Parameters:
//   WIDTH   counter width in bits (>= 2)
//   STEP_W  width of the step input (1..WIDTH)
//
// Ports:
//   clk       in  1       system clock, rising edge
//   reset     in  1       asynchronous active-low reset
//   clear     in  1       synchronous clear to 0
//   enable    in  1       count enable
//   up_down   in  1       1 = up, 0 = down
//   load      in  1       synchronous load of data_in (clamped to limit)
//   data_in   in  WIDTH   load value
//   step      in  STEP_W  step magnitude
//   limit     in  WIDTH   terminal value
//   sat_mode  in  1       1 = saturate, 0 = wrap modulo limit+1
//   count     out WIDTH   current count (registered)
//   at_max    out 1       count == limit (combinational)
//   at_min    out 1       count == 0 (combinational)
//   ovf       out 1       registered one-cycle overflow pulse
// ----------------------------------------------------------------------------
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              up_down,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf
);

    logic [WIDTH-1:0] calc_count;
    logic             calc_ovf;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count_d;
    logic             ovf_d;

    counter_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count      (count),
        .step       (step),
        .limit      (limit),
        .up_down    (up_down),
        .sat_mode   (sat_mode),
        .next_count (calc_count),
        .next_ovf   (calc_ovf)
    );

    // A load above the terminal value is clamped silently; it is a
    // configuration event, not a counting overflow.
    assign load_value = (data_in > limit) ? limit : data_in;

    // Control priority. ovf defaults low so it is a single-cycle pulse unless
    // an enabled count reports another overflow on the very next edge.
    always_comb begin
        count_d = count;
        ovf_d   = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (enable) begin
            count_d = calc_count;
            ovf_d   = calc_ovf;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            ovf   <= ovf_d;
        end
    end

    // Flags follow the live limit, so lowering limit updates at_max at once.
    assign at_max = (count == limit);
    assign at_min = (count == '0);

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Self-checking bench for updown_mod_counter (WIDTH=8, STEP_W=4). Inputs
// change one time unit after the falling edge, the DUT and the reference
// model update on the rising edge, and outputs are compared on the falling
// edge. The reference model works in plain integers from the counting rules
// (modulo arithmetic for wrap, clamps for saturate). Directed sequences with
// hand-computed literal expectations are followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_updown_mod_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    logic              clk;
    logic              reset;
    logic              clear;
    logic              enable;
    logic              up_down;
    logic              load;
    logic [WIDTH-1:0]  data_in;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              sat_mode;
    logic [WIDTH-1:0]  count;
    logic              at_max;
    logic              at_min;
    logic              ovf;

    int n_vec  = 0;
    int n_miss = 0;
    bit cmp_on = 1'b0;

    // Reference model state.
    int   m_count = 0;
    logic m_ovf   = 1'b0;

    updown_mod_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .enable   (enable),
        .up_down  (up_down),
        .load     (load),
        .data_in  (data_in),
        .step     (step),
        .limit    (limit),
        .sat_mode (sat_mode),
        .count    (count),
        .at_max   (at_max),
        .at_min   (at_min),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: integer arithmetic straight from the counting rules.
    always @(posedge clk or negedge reset) begin : model
        int lim;
        int e;
        int nc;
        logic o;
        if (!reset) begin
            m_count = 0;
            m_ovf   = 1'b0;
        end else begin
            lim = int'(limit);
            nc  = m_count;
            o   = 1'b0;
            if (clear) begin
                nc = 0;
            end else if (load) begin
                nc = (int'(data_in) > lim) ? lim : int'(data_in);
            end else if (enable) begin
                e = (int'(step) > lim + 1) ? lim + 1 : int'(step);
                if (m_count > lim) begin
                    nc = lim;
                    o  = 1'b1;
                end else if (up_down) begin
                    if (m_count + e > lim) begin
                        o  = 1'b1;
                        nc = sat_mode ? lim : (m_count + e) % (lim + 1);
                    end else begin
                        nc = m_count + e;
                    end
                end else begin
                    if (e > m_count) begin
                        o  = 1'b1;
                        nc = sat_mode ? 0 : (m_count - e + lim + 1) % (lim + 1);
                    end else begin
                        nc = m_count - e;
                    end
                end
            end
            m_count = nc;
            m_ovf   = o;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("count",  32'(count),  32'(m_count));
            check("ovf",    32'(ovf),    32'(m_ovf));
            check("at_max", 32'(at_max), 32'(m_count == int'(limit)));
            check("at_min", 32'(at_min), 32'(m_count == 0));
        end
    end

    // Apply one cycle of inputs, then return just after the next falling edge.
    task automatic apply(input logic c, input logic ld, input logic en,
                         input logic ud, input logic sm,
                         input int d, input int st, input int lim);
        clear    = c;
        load     = ld;
        enable   = en;
        up_down  = ud;
        sat_mode = sm;
        data_in  = WIDTH'(d);
        step     = STEP_W'(st);
        limit    = WIDTH'(lim);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int exp_seq[5];
        int exp_ovf[5];
        int lim_r;

        reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0;
        up_down = 1'b0; sat_mode = 1'b0; data_in = '0; step = '0; limit = 8'd9;

        // Reset state.
        #3;
        check("rst_count",  32'(count),  0);
        check("rst_ovf",    32'(ovf),    0);
        check("rst_at_min", 32'(at_min), 1);
        check("rst_at_max", 32'(at_max), 0);
        limit = 8'd0;
        #1;
        check("rst_at_max_lim0", 32'(at_max), 1);
        limit = 8'd9;
        #3;
        reset = 1'b1;
        @(negedge clk);
        #1;
        cmp_on = 1'b1;

        // Wrap, up, step 3, limit 9 from 0.
        exp_seq = '{3, 6, 9, 2, 5};
        exp_ovf = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 1, 0, 0, 3, 9);
            check("wrap_up_count", 32'(count), 32'(exp_seq[i]));
            check("wrap_up_ovf",   32'(ovf),   32'(exp_ovf[i]));
            if (i == 2) check("wrap_up_at_max", 32'(at_max), 1);
        end

        // Saturate, down, step 4 from 7.
        apply(0, 1, 0, 0, 1, 7, 0, 9);
        check("load7", 32'(count), 7);
        exp_seq = '{3, 0, 0, 0, 0};
        exp_ovf = '{0, 1, 1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 0, 1, 0, 4, 9);
            check("sat_dn_count", 32'(count), 32'(exp_seq[i]));
            check("sat_dn_ovf",   32'(ovf),   32'(exp_ovf[i]));
            if (i > 0) check("sat_dn_at_min", 32'(at_min), 1);
        end

        // Load clamp, then limit lowered under the count.
        apply(0, 1, 0, 1, 0, 200, 0, 100);
        check("clamp_count",  32'(count),  100);
        check("clamp_ovf",    32'(ovf),    0);
        check("clamp_at_max", 32'(at_max), 1);
        apply(0, 0, 1, 1, 0, 0, 1, 50);
        check("recover_count", 32'(count), 50);
        check("recover_ovf",   32'(ovf),   1);

        // Priority.
        apply(1, 1, 1, 1, 0, 5, 3, 50);
        check("prio_clear", 32'(count), 0);
        apply(0, 1, 1, 1, 0, 5, 3, 50);
        check("prio_load", 32'(count), 5);

        // Full-range limit, wrap past 255, then step 0.
        apply(0, 1, 0, 1, 0, 255, 0, 255);
        check("load255", 32'(count), 255);
        apply(0, 0, 1, 1, 0, 0, 1, 255);
        check("full_wrap_count", 32'(count), 0);
        check("full_wrap_ovf",   32'(ovf),   1);
        apply(0, 0, 1, 1, 0, 0, 0, 255);
        check("step0_count", 32'(count), 0);
        check("step0_ovf",   32'(ovf),   0);

        // Asynchronous reset between edges while ovf is high.
        apply(0, 1, 0, 1, 0, 254, 0, 255);
        apply(0, 0, 1, 1, 0, 0, 3, 255);
        check("pre_rst_count", 32'(count), 1);
        check("pre_rst_ovf",   32'(ovf),   1);
        enable = 1'b0;
        reset  = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 0);
        check("async_rst_ovf",   32'(ovf),   0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        apply(0, 0, 1, 1, 0, 0, 1, 255);
        check("post_rst_count", 32'(count), 1);

        // Randomized run.
        lim_r = 9;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 15) == 0)
                lim_r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20))
                                                    : int'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
            apply(logic'($urandom_range(0, 31) == 0),
                  logic'($urandom_range(0, 9) == 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)),
                  lim_r);
        end

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_updown_mod_counter
